// File: rtl/count_pkg.sv
// Shared types and helpers for the count-driven PWM monitor.
// Optional checker is enabled with the SEQ_CHECK_EN macro.
package count_pkg;

  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  function automatic int unsigned duty_clamp(
    input int unsigned d,
    input int unsigned w
  );
    int unsigned full;
    full = 32'd1 << w;
    return (d > full) ? full : d;
  endfunction

endpackage

// File: rtl/count_pwm_monitor_if.sv
// Bundle between the counter side and the PWM monitor.
// Optional checker outputs exist under SEQ_CHECK_EN; else tied to 0.
interface count_pwm_monitor_if #(
  parameter int CNT_W = 3
);
  logic             en;
  logic [CNT_W-1:0] cnt_in;
  logic [CNT_W:0]   duty_in;
  logic             duty_load;
  logic             pwm_out;
  logic             period_pulse;
  logic [CNT_W:0]   duty_active;
  logic             seq_err;
  logic [3:0]       err_count;
  logic             fault;

  modport master (
    output en, cnt_in, duty_in, duty_load,
    input  pwm_out, period_pulse, duty_active,
    input  seq_err, err_count, fault
  );

  modport slave (
    input  en, cnt_in, duty_in, duty_load,
    output pwm_out, period_pulse, duty_active,
    output seq_err, err_count, fault
  );
endinterface

// File: rtl/count_seq_checker.sv
// Verifies the count steps by +1 mod 2^CNT_W each cycle.
// Only instantiated when SEQ_CHECK_EN is defined.
module count_seq_checker #(
  parameter int CNT_W     = 3,
  parameter int ERR_LIMIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             check,
  input  logic             clear,
  output logic             seq_err,
  output logic [3:0]       err_count,
  output logic             hit
);

  logic [CNT_W-1:0] prev_cnt;
  logic [CNT_W-1:0] expect_cnt;
  logic [4:0]       cnt_nx;
  logic             brk;

  assign expect_cnt = prev_cnt + 1'b1;
  assign brk    = check && (cnt_in != expect_cnt);
  assign cnt_nx = {1'b0, err_count} + 5'd1;
  assign hit    = brk && (cnt_nx >= 5'(ERR_LIMIT));

  // track previous count and accumulate saturating break count
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt  <= '0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      prev_cnt <= cnt_in;
      seq_err  <= brk;
      if (clear)
        err_count <= '0;
      else if (brk && err_count != 4'hf)
        err_count <= err_count + 4'd1;
    end
  end

endmodule

// File: rtl/count_pwm_monitor.sv
// PWM generator and period tracker driven by an upstream counter.
// Define SEQ_CHECK_EN to add the sequence checker and FAULT state.
module count_pwm_monitor
  import count_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ERR_LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  count_pwm_monitor_if.slave bus
);

  if (ERR_LIMIT < 1 || ERR_LIMIT > 15) begin : g_bad_limit
    $error("ERR_LIMIT must be 1..15");
  end

  state_t         state;
  logic [CNT_W:0] shadow;
  logic [CNT_W:0] duty_q;
  logic [CNT_W:0] duty_nx;
  logic [CNT_W:0] clamped;
  logic           pwm_q;
  logic           pp_q;
  logic           fault_q;
  logic           wrap;
  logic           take;
  logic           lt;
  logic           hit;

  assign wrap    = (bus.cnt_in == '0);
  assign clamped = (CNT_W+1)'(duty_clamp(
                     32'(bus.duty_in), CNT_W));

  // select the duty for the upcoming period at wrap or RUN entry
  always_comb begin
    take    = 1'b0;
    duty_nx = duty_q;
    if (bus.en && wrap &&
        (state == SYNC || state == RUN))
      take = 1'b1;
    if (take)
      duty_nx = shadow;
    lt = ({1'b0, bus.cnt_in} < duty_nx);
  end

`ifdef SEQ_CHECK_EN
  logic fresh;
  logic chk;
  logic clr;

  assign chk = (state == RUN) && bus.en && !fresh;
  assign clr = !bus.en || state == IDLE ||
               state == SYNC;

  // skip the comparison in the first RUN cycle after SYNC
  always_ff @(posedge clk) begin
    if (reset)
      fresh <= 1'b0;
    else
      fresh <= (state == SYNC) && bus.en && wrap;
  end

  count_seq_checker #(
    .CNT_W     (CNT_W),
    .ERR_LIMIT (ERR_LIMIT)
  ) u_seq_checker (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (bus.cnt_in),
    .check     (chk),
    .clear     (clr),
    .seq_err   (bus.seq_err),
    .err_count (bus.err_count),
    .hit       (hit)
  );
`else
  assign hit           = 1'b0;
  assign bus.seq_err   = 1'b0;
  assign bus.err_count = '0;
`endif

  // mode FSM with registered PWM, period pulse and fault
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shadow  <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      pp_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (bus.duty_load)
        shadow <= clamped;
      duty_q  <= duty_nx;
      pwm_q   <= 1'b0;
      pp_q    <= 1'b0;
      fault_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en)
            state <= SYNC;
        end
        SYNC: begin
          if (!bus.en) begin
            state <= IDLE;
          end else if (wrap) begin
            state <= RUN;
            pwm_q <= lt;
            pp_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.en) begin
            state <= IDLE;
          end else if (hit) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end else begin
            pwm_q <= lt;
            pp_q  <= wrap;
          end
        end
        FAULT: begin
          if (!bus.en)
            state <= IDLE;
          else
            fault_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_pulse = pp_q;
  assign bus.duty_active  = duty_q;
  assign bus.fault        = fault_q;

endmodule

// File: doc/count_pwm_monitor.md
Name: count_pwm_monitor

Overview:
- Downstream consumer of the 3-bit synchronous up counter's Q bus; same clk, same synchronous reset.
- Turns the free-running count into a registered PWM output with a glitch-free, period-aligned duty update.
- Emits a start-of-period pulse.
- Checks that the incoming count advances by exactly +1 mod 2^CNT_W every cycle, and latches a fault when it does not.

Parameters:
- CNT_W, 3, width of incoming count; period = 2^CNT_W cycles.
- ERR_LIMIT, 2, sequence errors (saturating count) that force FAULT; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- en  input  1  monitor/PWM enable.
- cnt_in  input  CNT_W  count from upstream counter.
- duty_in  input  CNT_W+1  requested high cycles per period, 0..2^CNT_W.
- duty_load  input  1  one-cycle strobe; captures duty_in into shadow register.
- pwm_out  output  1  registered PWM.
- period_pulse  output  1  one-cycle pulse at start of each RUN period.
- duty_active  output  CNT_W+1  duty value in effect this period.
- seq_err  output  1  one-cycle pulse per detected sequence break.
- err_count  output  4  saturating count of sequence breaks since entering RUN.
- fault  output  1  high while in FAULT.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: all outputs 0; duty_shadow 0; duty_active 0; prev_cnt 0; state IDLE.
- Reset mid-operation: reset dominates on the same edge. Every other input is ignored that cycle.

FSM states and transitions:
- IDLE:
  - en=1 goes to SYNC.
  - pwm_out=0.
- SYNC:
  - Waits for cnt_in==0.
  - On that edge: go to RUN, load duty_active from duty_shadow, assert period_pulse next cycle.
  - en=0 goes to IDLE.
- RUN:
  - Normal operation.
  - en=0 goes to IDLE; err_count clears and duty_active is held.
  - err_count reaching ERR_LIMIT goes to FAULT.
- FAULT:
  - pwm_out=0, fault=1.
  - Exit only via reset or en=0 (to IDLE).

PWM:
- In RUN, pwm_out registered as (cnt_in < duty_active); 1-cycle latency from cnt_in.
- duty_active=0 gives a constant 0.
- duty_active=2^CNT_W gives a constant 1.

Duty update:
- duty_load=1 captures duty_in into duty_shadow on that edge.
- duty_in > 2^CNT_W clamps to 2^CNT_W.
- duty_active updates from duty_shadow only on an edge where cnt_in==0 (wrap) in RUN, or on the SYNC->RUN edge. A mid-period load never alters the current period.
- duty_load coincident with wrap: the new duty_in value does not reach duty_active at that wrap; it takes effect at the following wrap.

period_pulse:
- Registered; high in the cycle after cnt_in==0 is sampled in RUN, or after the SYNC->RUN edge.

Sequence check:
- prev_cnt registers cnt_in every cycle.
- In RUN, any cnt_in != prev_cnt+1 (mod 2^CNT_W) is a break:
  - seq_err pulses next cycle.
  - err_count increments, saturating at 15.
- First RUN cycle after SYNC is not checked (prev_cnt is treated as valid from SYNC).
- Wrap 7->0 is legal.
- Break and wrap on the same cycle: both take effect independently.

Optional Feature:
- Macro: SEQ_CHECK_EN.
- Defined: sequence checker, seq_err, err_count and the FAULT state are present as above.
- Undefined: no checker logic; seq_err=0, err_count=0, fault=0; FAULT unreachable; RUN exits only on en=0.

Decomposition:
- Package count_pkg holds:
  - state enum {IDLE, SYNC, RUN, FAULT} (2 bits);
  - CNT_W default constant;
  - function duty_clamp(duty_in).
- One sub-module: count_seq_checker (prev_cnt register, compare, saturating err_count). Instantiated only under SEQ_CHECK_EN.

Test Plan:
1. Reset then en=1 with counter running, duty_in=3 loaded in IDLE -> SYNC until cnt_in=0; thereafter pwm_out high for cnt 0,1,2 (1-cycle late), low for 3..7; period_pulse every 8 cycles.
2. Mid-period duty_load, duty_in=6 at cnt_in=4 -> current period still 3 high; next period 6 high; duty_active changes to 6 exactly at cnt_in=0.
3. Boundaries: duty_in=0 -> pwm_out constantly 0; duty_in=8 -> constantly 1; duty_in=15 -> clamped to 8, constantly 1.
4. Inject skip cnt_in 2->4, then later 5->5 (SEQ_CHECK_EN) -> seq_err pulses twice, err_count=2, fault=1, pwm_out=0; en=0 then en=1 -> IDLE->SYNC->RUN with err_count=0.
5. Reset asserted during RUN at cnt_in=5 -> next cycle all outputs 0, state IDLE; with counter also reset, en held 1 -> RUN entered on the first cnt_in=0.
6. Build without SEQ_CHECK_EN plus the injected skips from test 4 -> seq_err/fault stay 0, PWM continues uninterrupted.
